// File: rtl/icache_refill_ctrl.sv
// Instruction-cache refill controller.
// Clears every tag entry after reset or on request, and on a lookup miss
// fetches the whole line with one AXI4 INCR burst before committing its tag.
// It is the sole writer of both the data array and the tag array.

package icache_pkg;
    localparam int unsigned WDSZ        = 32;
    localparam int unsigned LADDRSZ     = 8;
    localparam int unsigned WADDRSZ     = 6;
    localparam int unsigned BADDRSZ     = 3;
    localparam int unsigned TAGSZ       = 15;
    localparam int unsigned LNUM        = 256;
    localparam int unsigned AXI_WIDTH   = 64;
    localparam int unsigned WBKSZ       = 2;
    localparam int unsigned ALLOC_BEATS = 32;

    typedef struct packed {
        logic [TAGSZ-1:0]   tag;
        logic [LADDRSZ-1:0] laddr;
        logic [WADDRSZ-1:0] waddr;
        logic [BADDRSZ-1:0] baddr;
    } addr_t;

    typedef struct packed {
        logic [TAGSZ-1:0] tag;
        logic             valid;
        logic             dirty;
    } overhead_t;
endpackage

module icache_refill_ctrl
    import icache_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 miss_valid,
    input  logic [WDSZ-1:0]      miss_addr,
    output logic                 miss_ready,
    input  logic                 inv_req,
    output logic                 inv_done,
    output logic                 refill_done,
    output logic                 refill_err,
    output logic                 busy,
    output logic [WDSZ-1:0]      araddr,
    output logic [7:0]           arlen,
    output logic [2:0]           arsize,
    output logic [1:0]           arburst,
    output logic                 arvalid,
    input  logic                 arready,
    input  logic [AXI_WIDTH-1:0] rdata,
    input  logic [1:0]           rresp,
    input  logic                 rlast,
    input  logic                 rvalid,
    output logic                 rready,
    output logic                 data_we,
    output logic [LADDRSZ-1:0]   data_laddr,
    output logic [WADDRSZ-1:0]   data_waddr,
    output logic [AXI_WIDTH-1:0] data_wdata,
    output logic                 tag_we,
    output logic [LADDRSZ-1:0]   tag_laddr,
    output logic [TAGSZ+1:0]     tag_wdata
);

    typedef enum logic [2:0] {
        S_INV,
        S_IDLE,
        S_AR,
        S_RD,
        S_COMMIT
    } state_t;

    localparam int unsigned        BEATW     = $clog2(ALLOC_BEATS);
    localparam int unsigned        LOFF      = WADDRSZ + BADDRSZ;
    localparam logic [BEATW-1:0]   LAST_BEAT = BEATW'(ALLOC_BEATS - 1);
    localparam logic [LADDRSZ-1:0] LAST_SET  = LADDRSZ'(LNUM - 1);
    localparam logic [WDSZ-1:0]    LINE_MASK = WDSZ'((1 << LOFF) - 1);

    state_t             state_q;
    logic [LADDRSZ-1:0] inv_cnt_q;
    logic [BEATW-1:0]   beat_cnt_q;
    logic               err_q;
    logic [WDSZ-1:0]    addr_q;

    logic               count_last;
    logic [LADDRSZ-1:0] line_laddr;
    logic [TAGSZ-1:0]   line_tag;
    overhead_t          commit_ovh;

    assign count_last = (beat_cnt_q == LAST_BEAT);
    assign line_laddr = addr_q[LOFF +: LADDRSZ];
    assign line_tag   = addr_q[WDSZ-1 -: TAGSZ];

    // Burst shape is fixed; the address is the latched miss with its line offset cleared.
    assign arlen      = 8'(ALLOC_BEATS - 1);
    assign arsize     = 3'd3;
    assign arburst    = 2'b01;
    assign araddr     = addr_q & ~LINE_MASK;
    assign data_laddr = line_laddr;
    assign data_waddr = WADDRSZ'(32'(beat_cnt_q) * WBKSZ);
    assign data_wdata = rdata;
    assign busy       = (state_q != S_IDLE);

    // Sweep / accept / burst / commit sequencing.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= S_INV;
            inv_cnt_q  <= '0;
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
            addr_q     <= '0;
        end else begin
            case (state_q)
                S_INV: begin
                    inv_cnt_q <= inv_cnt_q + LADDRSZ'(1);
                    if (inv_cnt_q == LAST_SET) begin
                        state_q <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (inv_req) begin
                        inv_cnt_q <= '0;
                        state_q   <= S_INV;
                    end else if (miss_valid) begin
                        addr_q  <= miss_addr;
                        state_q <= S_AR;
                    end
                end
                S_AR: begin
                    if (arready) begin
                        beat_cnt_q <= '0;
                        err_q      <= 1'b0;
                        state_q    <= S_RD;
                    end
                end
                S_RD: begin
                    if (rvalid) begin
                        beat_cnt_q <= beat_cnt_q + BEATW'(1);
                        // A bad response or rlast disagreeing with the beat count both poison the line.
                        if ((rresp != 2'b00) || (rlast != count_last)) begin
                            err_q <= 1'b1;
                        end
                        if (rlast || count_last) begin
                            state_q <= S_COMMIT;
                        end
                    end
                end
                S_COMMIT: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_INV;
                end
            endcase
        end
    end

    // Strobes decoded from the current state; all forced low while reset is held.
    always_comb begin
        miss_ready       = 1'b0;
        inv_done         = 1'b0;
        refill_done      = 1'b0;
        refill_err       = 1'b0;
        arvalid          = 1'b0;
        rready           = 1'b0;
        data_we          = 1'b0;
        tag_we           = 1'b0;
        tag_laddr        = inv_cnt_q;
        commit_ovh       = '0;
        commit_ovh.tag   = line_tag;
        commit_ovh.valid = ~err_q;
        commit_ovh.dirty = 1'b0;
        tag_wdata        = '0;
        if (reset_n) begin
            case (state_q)
                S_INV: begin
                    tag_we   = 1'b1;
                    inv_done = (inv_cnt_q == LAST_SET);
                end
                S_IDLE: begin
                    miss_ready = miss_valid && !inv_req;
                end
                S_AR: begin
                    arvalid = 1'b1;
                end
                S_RD: begin
                    rready  = 1'b1;
                    data_we = rvalid;
                end
                S_COMMIT: begin
                    tag_we      = 1'b1;
                    tag_laddr   = line_laddr;
                    tag_wdata   = commit_ovh;
                    refill_done = 1'b1;
                    refill_err  = err_q;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed self-checking bench for icache_refill_ctrl.
// Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.

module tb_icache_refill_ctrl;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        miss_valid;
    logic [31:0] miss_addr;
    logic        miss_ready;
    logic        inv_req;
    logic        inv_done;
    logic        refill_done;
    logic        refill_err;
    logic        busy;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic        data_we;
    logic [7:0]  data_laddr;
    logic [5:0]  data_waddr;
    logic [63:0] data_wdata;
    logic        tag_we;
    logic [7:0]  tag_laddr;
    logic [16:0] tag_wdata;

    int pass_cnt  = 0;
    int total_cnt = 0;

    icache_refill_ctrl dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .miss_valid (miss_valid),
        .miss_addr  (miss_addr),
        .miss_ready (miss_ready),
        .inv_req    (inv_req),
        .inv_done   (inv_done),
        .refill_done(refill_done),
        .refill_err (refill_err),
        .busy       (busy),
        .araddr     (araddr),
        .arlen      (arlen),
        .arsize     (arsize),
        .arburst    (arburst),
        .arvalid    (arvalid),
        .arready    (arready),
        .rdata      (rdata),
        .rresp      (rresp),
        .rlast      (rlast),
        .rvalid     (rvalid),
        .rready     (rready),
        .data_we    (data_we),
        .data_laddr (data_laddr),
        .data_waddr (data_waddr),
        .data_wdata (data_wdata),
        .tag_we     (tag_we),
        .tag_laddr  (tag_laddr),
        .tag_wdata  (tag_wdata)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Expects to be called in the first INV cycle with reset released.
    task automatic sweep_check(input string name);
        for (int i = 0; i < 256; i++) begin
            total_cnt++;
            if ({tag_we, tag_laddr, tag_wdata, inv_done, miss_ready, busy} !==
                {1'b1, 8'(i), 17'd0, (i == 255), 1'b0, 1'b1})
                $display("FAIL %s cycle %0d: got we=%b laddr=%h wdata=%h done=%b mrdy=%b busy=%b exp we=1 laddr=%h wdata=0 done=%b mrdy=0 busy=1",
                         name, i, tag_we, tag_laddr, tag_wdata, inv_done, miss_ready, busy, 8'(i), (i == 255));
            else
                pass_cnt++;
            tick();
        end
        total_cnt++;
        if ({busy, tag_we, inv_done} !== 3'b000)
            $display("FAIL %s after: got busy=%b tag_we=%b inv_done=%b exp 0 0 0", name, busy, tag_we, inv_done);
        else
            pass_cnt++;
    endtask

    // Full refill from an IDLE cycle; leaves the DUT in the next IDLE cycle.
    task automatic run_refill(input string name, input logic [31:0] addr, input logic [31:0] exp_araddr,
                              input logic [7:0] exp_laddr, input logic [14:0] exp_tag,
                              input int ar_delay, input bit toggle, input int bad_beat,
                              input int last_beat, input bit exp_err);
        int beats;
        int writes;
        int cyc;
        miss_addr  = addr;
        miss_valid = 1'b1;
        #1;
        total_cnt++;
        if (miss_ready !== 1'b1)
            $display("FAIL %s miss_ready: got %b exp 1", name, miss_ready);
        else
            pass_cnt++;
        tick();
        miss_valid = 1'b0;
        miss_addr  = '0;
        for (int d = 0; d <= ar_delay; d++) begin
            arready = (d == ar_delay);
            #1;
            total_cnt++;
            if ({arvalid, araddr, arlen, arsize, arburst, rready} !==
                {1'b1, exp_araddr, 8'd31, 3'd3, 2'b01, 1'b0})
                $display("FAIL %s ar wait %0d: got vld=%b addr=%h len=%0d size=%0d burst=%0d rrdy=%b exp vld=1 addr=%h len=31 size=3 burst=1 rrdy=0",
                         name, d, arvalid, araddr, arlen, arsize, arburst, rready, exp_araddr);
            else
                pass_cnt++;
            tick();
        end
        arready = 1'b0;
        beats   = 0;
        writes  = 0;
        cyc     = 0;
        while (beats <= last_beat && cyc < 200) begin
            rvalid = toggle ? cyc[0] : 1'b1;
            rdata  = 64'hC0DE_0000_0000_0000 | 64'(beats);
            rresp  = (beats == bad_beat) ? 2'b10 : 2'b00;
            rlast  = (beats == last_beat);
            #1;
            if (data_we === 1'b1) writes++;
            total_cnt++;
            if (rvalid) begin
                if ({rready, data_we, data_laddr, data_waddr, data_wdata} !==
                    {1'b1, 1'b1, exp_laddr, 6'(beats * 2), rdata})
                    $display("FAIL %s beat %0d: got rrdy=%b we=%b laddr=%h waddr=%0d wdata=%h exp rrdy=1 we=1 laddr=%h waddr=%0d wdata=%h",
                             name, beats, rready, data_we, data_laddr, data_waddr, data_wdata,
                             exp_laddr, 6'(beats * 2), rdata);
                else
                    pass_cnt++;
                beats++;
            end else begin
                if ({rready, data_we} !== 2'b10)
                    $display("FAIL %s idle beat slot: got rrdy=%b we=%b exp rrdy=1 we=0", name, rready, data_we);
                else
                    pass_cnt++;
            end
            tick();
            cyc++;
        end
        total_cnt++;
        if (beats !== last_beat + 1)
            $display("FAIL %s beat budget: got %0d beats exp %0d", name, beats, last_beat + 1);
        else
            pass_cnt++;
        // An extra beat presented in COMMIT must be refused.
        rvalid = 1'b1;
        rlast  = 1'b0;
        rresp  = 2'b00;
        #1;
        total_cnt++;
        if ({tag_we, tag_laddr, tag_wdata, refill_done, refill_err, data_we, rready} !==
            {1'b1, exp_laddr, {exp_tag, ~exp_err, 1'b0}, 1'b1, exp_err, 1'b0, 1'b0})
            $display("FAIL %s commit: got we=%b laddr=%h wdata=%h done=%b err=%b dwe=%b rrdy=%b exp we=1 laddr=%h wdata=%h done=1 err=%b dwe=0 rrdy=0",
                     name, tag_we, tag_laddr, tag_wdata, refill_done, refill_err, data_we, rready,
                     exp_laddr, {exp_tag, ~exp_err, 1'b0}, exp_err);
        else
            pass_cnt++;
        total_cnt++;
        if (writes !== last_beat + 1)
            $display("FAIL %s write count: got %0d exp %0d", name, writes, last_beat + 1);
        else
            pass_cnt++;
        tick();
        rvalid = 1'b0;
        #1;
        total_cnt++;
        if ({busy, refill_done, tag_we, data_we} !== 4'b0000)
            $display("FAIL %s back to idle: got busy=%b done=%b tag_we=%b data_we=%b exp 0 0 0 0",
                     name, busy, refill_done, tag_we, data_we);
        else
            pass_cnt++;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        total_cnt++;
        if ({tag_we, data_we, arvalid, rready, miss_ready, inv_done, refill_done, refill_err, busy, araddr} !==
            {8'h00, 1'b1, 32'h0})
            $display("FAIL reset_state: got tag_we=%b data_we=%b arvalid=%b rready=%b mrdy=%b inv_done=%b rdone=%b rerr=%b busy=%b araddr=%h exp all 0 busy=1 araddr=0",
                     tag_we, data_we, arvalid, rready, miss_ready, inv_done, refill_done, refill_err, busy, araddr);
        else
            pass_cnt++;
        reset_n = 1'b1;
        #1;
        sweep_check("reset_sweep");
    endtask

    task automatic test_refill_basic();
        run_refill("basic", 32'h0001_2345, 32'h0001_2200, 8'h91, 15'h0000, 0, 1'b0, -1, 31, 1'b0);
    endtask

    task automatic test_refill_stall();
        run_refill("stall", 32'h0001_2345, 32'h0001_2200, 8'h91, 15'h0000, 5, 1'b1, -1, 31, 1'b0);
    endtask

    task automatic test_rresp_err();
        run_refill("rresp_err", 32'h0001_2345, 32'h0001_2200, 8'h91, 15'h0000, 0, 1'b0, 7, 31, 1'b1);
    endtask

    task automatic test_burst_len_err();
        run_refill("early_rlast", 32'h0ABC_DE00, 32'h0ABC_DE00, 8'h6F, 15'h055E, 1, 1'b0, -1, 15, 1'b1);
    endtask

    task automatic test_back_to_back();
        run_refill("b2b_first", 32'hFFFF_FFFF, 32'hFFFF_FE00, 8'hFF, 15'h7FFF, 0, 1'b0, -1, 31, 1'b0);
        run_refill("b2b_second", 32'h0001_2345, 32'h0001_2200, 8'h91, 15'h0000, 0, 1'b0, -1, 31, 1'b0);
    endtask

    task automatic test_inv_priority();
        inv_req    = 1'b1;
        miss_valid = 1'b1;
        miss_addr  = 32'h0001_2345;
        #1;
        total_cnt++;
        if ({miss_ready, busy} !== 2'b00)
            $display("FAIL inv_prio idle: got mrdy=%b busy=%b exp 0 0", miss_ready, busy);
        else
            pass_cnt++;
        tick();
        inv_req = 1'b0;
        #1;
        sweep_check("inv_prio_sweep");
        run_refill("inv_prio_miss", 32'h0001_2345, 32'h0001_2200, 8'h91, 15'h0000, 0, 1'b0, -1, 31, 1'b0);
    endtask

    task automatic test_reset_mid_rd();
        miss_addr  = 32'h0001_2345;
        miss_valid = 1'b1;
        tick();
        miss_valid = 1'b0;
        arready    = 1'b1;
        tick();
        arready = 1'b0;
        for (int b = 0; b < 10; b++) begin
            rvalid = 1'b1;
            rdata  = 64'(b);
            rlast  = 1'b0;
            tick();
        end
        rvalid  = 1'b1;
        rdata   = 64'd10;
        reset_n = 1'b0;
        tick();
        rvalid = 1'b0;
        #1;
        total_cnt++;
        if ({tag_we, data_we, arvalid, rready, miss_ready, inv_done, refill_done, busy} !== 8'b0000_0001)
            $display("FAIL rst_mid_rd: got tag_we=%b data_we=%b arvalid=%b rready=%b mrdy=%b inv_done=%b rdone=%b busy=%b exp all 0 busy=1",
                     tag_we, data_we, arvalid, rready, miss_ready, inv_done, refill_done, busy);
        else
            pass_cnt++;
        reset_n = 1'b1;
        #1;
        sweep_check("rst_mid_rd_sweep");
    endtask

    initial begin
        reset_n    = 1'b0;
        miss_valid = 1'b0;
        miss_addr  = '0;
        inv_req    = 1'b0;
        arready    = 1'b0;
        rdata      = '0;
        rresp      = 2'b00;
        rlast      = 1'b0;
        rvalid     = 1'b0;
        test_reset();
        test_refill_basic();
        test_refill_stall();
        test_rresp_err();
        test_burst_len_err();
        test_back_to_back();
        test_inv_priority();
        test_reset_mid_rd();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
